powlib_sfifo_lvl: RTL and testbench

Synchronous single-clock FIFO with valid/ready on both sides. It is the parametrised successor to the team's basic synchronous FIFO. Unlike that FIFO it uses all D entries, accepts any depth D ≥ 2 (not only powers of two), and reports its fill level. It also provides almost-full and almost-empty flags and a synchronous flush, so stream buffers and DMA front-ends can pace themselves.

---
 rtl/powlib_sfifo_lvl.sv | 170 +++++++++++++++++
 tb/tb_powlib_sfifo_lvl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/powlib_sfifo_lvl.sv
// powlib_sfifo_lvl: single-clock valid/ready FIFO with fill level, almost-full/empty flags and flush.
// Optional registered output stage: define POWLIB_SFIFO_LVL_OUTREG_EN (capacity D+1, latency 2).

package powlib_sfifo_lvl_pkg;
  function automatic int powlib_clogb2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction
endpackage

module powlib_dpram #(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WPTR = 3
) (
  input  logic            clk,
  input  logic            wren,
  input  logic [WPTR-1:0] wraddr,
  input  logic [W-1:0]    wrdata,
  input  logic [WPTR-1:0] rdaddr,
  output logic [W-1:0]    rddata
);
  logic [W-1:0] mem_r [D];

  // Synchronous write; the read port is asynchronous so the head falls through.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem_r[wraddr] <= wrdata;
    end
  end

  assign rddata = mem_r[rdaddr];
endmodule

module powlib_sfifo_lvl #(
  parameter int W      = 16,
  parameter int D      = 8,
  parameter int AFULL  = D - 2,
  parameter int AEMPTY = 2,
`ifdef POWLIB_SFIFO_LVL_OUTREG_EN
  localparam int CAP   = D + 1,
`else
  localparam int CAP   = D,
`endif
  localparam int WPTR  = powlib_sfifo_lvl_pkg::powlib_clogb2(D),
  localparam int WCNT  = powlib_sfifo_lvl_pkg::powlib_clogb2(CAP + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    wrdata,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic [W-1:0]    rddata,
  output logic            rdvld,
  input  logic            rdrdy,
  input  logic            flush,
  output logic [WCNT-1:0] count,
  output logic            afull,
  output logic            aempty
);
  logic [WPTR-1:0] wrptr_r;
  logic [WPTR-1:0] rdptr_r;
  logic [WCNT-1:0] count_r;
  logic [WCNT-1:0] count_nxt_s;
  logic            afull_r;
  logic            aempty_r;
  logic            wrinc_s;
  logic            rdinc_s;
  logic            pop_s;
  logic [W-1:0]    ramq_s;

  // Explicit compare-and-wrap so depths that are not powers of two work.
  function automatic logic [WPTR-1:0] next_ptr(input logic [WPTR-1:0] ptr);
    logic [WPTR-1:0] nxt;
    if (ptr == WPTR'(D - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + WPTR'(1);
    end
    return nxt;
  endfunction

  assign wrrdy   = rst && (count_r != WCNT'(CAP)) && !flush;
  assign wrinc_s = wrvld && wrrdy;
  assign rdinc_s = rdvld && rdrdy;
  assign count   = count_r;
  assign afull   = afull_r;
  assign aempty  = aempty_r;

  powlib_dpram #(
    .W    (W),
    .D    (D),
    .WPTR (WPTR)
  ) u_ram (
    .clk    (clk),
    .wren   (wrinc_s),
    .wraddr (wrptr_r),
    .wrdata (wrdata),
    .rdaddr (rdptr_r),
    .rddata (ramq_s)
  );

`ifdef POWLIB_SFIFO_LVL_OUTREG_EN
  logic         ovld_r;
  logic [W-1:0] odata_r;

  // The RAM holds count minus the output entry; reload when the stage is empty or being read.
  assign pop_s  = (!ovld_r || rdrdy) && (count_r > WCNT'(ovld_r));
  assign rdvld  = ovld_r;
  assign rddata = odata_r;

  // Output register stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovld_r  <= 1'b0;
      odata_r <= '0;
    end else if (flush) begin
      ovld_r  <= 1'b0;
    end else if (pop_s) begin
      ovld_r  <= 1'b1;
      odata_r <= ramq_s;
    end else if (rdinc_s) begin
      ovld_r  <= 1'b0;
    end else begin
      ovld_r  <= ovld_r;
    end
  end
`else
  assign pop_s  = rdinc_s;
  assign rdvld  = (count_r != '0);
  assign rddata = ramq_s;
`endif

  // Next fill level from the two handshakes.
  always_comb begin
    count_nxt_s = count_r;
    if (wrinc_s && !rdinc_s) begin
      count_nxt_s = count_r + WCNT'(1);
    end else if (rdinc_s && !wrinc_s) begin
      count_nxt_s = count_r - WCNT'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, level and almost flags; flush clears exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wrptr_r  <= '0;
      rdptr_r  <= '0;
      count_r  <= '0;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else begin
      if (wrinc_s) begin
        wrptr_r <= next_ptr(wrptr_r);
      end
      if (pop_s) begin
        rdptr_r <= next_ptr(rdptr_r);
      end
      count_r  <= count_nxt_s;
      afull_r  <= (count_nxt_s >= WCNT'(AFULL));
      aempty_r <= (count_nxt_s <= WCNT'(AEMPTY));
    end
  end
endmodule

// File: tb/tb_powlib_sfifo_lvl.sv
// Self-checking bench for powlib_sfifo_lvl against a queue model with per-entry visibility delay.
module tb_powlib_sfifo_lvl;
  localparam int W      = 8;
  localparam int D      = 5;
  localparam int AFULL  = 4;
  localparam int AEMPTY = 1;
`ifdef POWLIB_SFIFO_LVL_OUTREG_EN
  localparam int CAP     = D + 1;
  localparam int VIS_DLY = 1;
`else
  localparam int CAP     = D;
  localparam int VIS_DLY = 0;
`endif
  localparam int WCNT = $clog2(CAP + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    wrdata;
  logic            wrvld;
  logic            wrrdy;
  logic [W-1:0]    rddata;
  logic            rdvld;
  logic            rdrdy;
  logic            flush;
  logic [WCNT-1:0] count;
  logic            afull;
  logic            aempty;

  int checks = 0;
  int errors = 0;

  // Model: stored words plus the edge index at which each was written.
  logic [W-1:0] mq[$];
  int           ms[$];
  int           ecnt = 0;

  powlib_sfifo_lvl #(.W(W), .D(D), .AFULL(AFULL), .AEMPTY(AEMPTY)) dut (
    .clk(clk), .rst(rst), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
    .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy), .flush(flush),
    .count(count), .afull(afull), .aempty(aempty)
  );

  always #5 clk = ~clk;

  function automatic bit m_rdvld();
    if (mq.size() == 0) return 1'b0;
    return (ecnt - ms[0]) >= VIS_DLY;
  endfunction

  function automatic bit m_wrrdy();
    return rst && !flush && (mq.size() != CAP);
  endfunction

  // Advance one clock edge and update the model from the handshakes at that edge.
  task automatic tick();
    bit m_wrinc;
    bit m_rdinc;
    m_wrinc = wrvld && m_wrrdy();
    m_rdinc = m_rdvld() && rdrdy;
    @(posedge clk);
    ecnt++;
    if (!rst || flush) begin
      mq.delete();
      ms.delete();
    end else begin
      if (m_rdinc) begin
        void'(mq.pop_front());
        void'(ms.pop_front());
      end
      if (m_wrinc) begin
        mq.push_back(wrdata);
        ms.push_back(ecnt);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wrvld = 1'b0; rdrdy = 1'b0; flush = 1'b0; wrdata = '0;
    tick(); tick();
    checks++; if (wrrdy !== 1'b0) begin errors++; $display("FAIL reset_wrrdy got %b exp 0", wrrdy); end
    checks++; if (rdvld !== 1'b0) begin errors++; $display("FAIL reset_rdvld got %b exp 0", rdvld); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (aempty !== 1'b1 || afull !== 1'b0) begin errors++; $display("FAIL reset_flags got ae=%b af=%b exp ae=1 af=0", aempty, afull); end
    rst = 1'b1;
    tick();
    checks++; if (wrrdy !== 1'b1) begin errors++; $display("FAIL idle_wrrdy got %b exp 1", wrrdy); end
    checks++; if (rdvld !== 1'b0 || count !== '0) begin errors++; $display("FAIL idle_state got vld=%b cnt=%0d exp 0/0", rdvld, count); end
  endtask

  task automatic test_fill_drain();
    int exp_v;
    int guard;
    rdrdy = 1'b0; wrvld = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      wrdata = W'(i + 1);
      tick();
    end
    wrvld = 1'b0;
    tick();
    checks++; if (count !== WCNT'(CAP)) begin errors++; $display("FAIL full_count got %0d exp %0d", count, CAP); end
    checks++; if (wrrdy !== 1'b0) begin errors++; $display("FAIL full_wrrdy got %b exp 0", wrrdy); end
    checks++; if (afull !== 1'b1 || aempty !== 1'b0) begin errors++; $display("FAIL full_flags got af=%b ae=%b exp 1/0", afull, aempty); end
    checks++; if (rdvld !== 1'b1 || rddata !== 8'h01) begin errors++; $display("FAIL full_head got vld=%b data=%h exp 1/01", rdvld, rddata); end
    wrvld = 1'b1; wrdata = 8'hEE;
    tick();
    wrvld = 1'b0;
    checks++; if (count !== WCNT'(CAP)) begin errors++; $display("FAIL full_refuse got %0d exp %0d", count, CAP); end
    rdrdy = 1'b1; exp_v = 1; guard = 0;
    while (exp_v <= CAP && guard < 4 * CAP) begin
      if (rdvld === 1'b1) begin
        checks++; if (rddata !== W'(exp_v)) begin errors++; $display("FAIL drain_data got %h exp %h", rddata, W'(exp_v)); end
        exp_v++;
      end
      tick();
      guard++;
    end
    rdrdy = 1'b0;
    checks++; if (exp_v != CAP + 1) begin errors++; $display("FAIL drain_timeout got %0d words exp %0d", exp_v - 1, CAP); end
    checks++; if (count !== '0 || rdvld !== 1'b0 || aempty !== 1'b1) begin errors++; $display("FAIL drain_empty got cnt=%0d vld=%b ae=%b exp 0/0/1", count, rdvld, aempty); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] nexp;
    int nrd;
    int guard;
    wrvld = 1'b1; rdrdy = 1'b1; nexp = 8'h10; nrd = 0;
    for (int i = 0; i < 20; i++) begin
      wrdata = W'(8'h10 + i);
      if (i >= 1 + VIS_DLY) begin
        checks++; if (count !== WCNT'(1 + VIS_DLY)) begin errors++; $display("FAIL b2b_count i=%0d got %0d exp %0d", i, count, 1 + VIS_DLY); end
      end
      if (rdvld === 1'b1) begin
        checks++; if (rddata !== nexp) begin errors++; $display("FAIL b2b_data got %h exp %h", rddata, nexp); end
        nexp++; nrd++;
      end
      tick();
    end
    wrvld = 1'b0; guard = 0;
    while (nrd < 20 && guard < 10) begin
      if (rdvld === 1'b1) begin
        checks++; if (rddata !== nexp) begin errors++; $display("FAIL b2b_tail got %h exp %h", rddata, nexp); end
        nexp++; nrd++;
      end
      tick();
      guard++;
    end
    rdrdy = 1'b0;
    checks++; if (nrd != 20) begin errors++; $display("FAIL b2b_total got %0d exp 20", nrd); end
  endtask

  task automatic test_full_rw();
    rdrdy = 1'b0; wrvld = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      wrdata = W'(8'h40 + i);
      tick();
    end
    wrvld = 1'b0;
    tick();
    wrvld = 1'b1; rdrdy = 1'b1; wrdata = 8'h99;
    #1;
    checks++; if (wrrdy !== 1'b0 || rdvld !== 1'b1) begin errors++; $display("FAIL fullrw_hs got wrrdy=%b rdvld=%b exp 0/1", wrrdy, rdvld); end
    tick();
    wrvld = 1'b0; rdrdy = 1'b0;
    checks++; if (count !== WCNT'(CAP - 1)) begin errors++; $display("FAIL fullrw_count got %0d exp %0d", count, CAP - 1); end
    tick();
    checks++; if (rdvld !== 1'b1 || rddata !== 8'h41) begin errors++; $display("FAIL fullrw_next got vld=%b data=%h exp 1/41", rdvld, rddata); end
    rdrdy = 1'b1;
    for (int i = 0; i < 2 * CAP + 2; i++) tick();
    rdrdy = 1'b0;
    checks++; if (count !== '0) begin errors++; $display("FAIL fullrw_drain got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    int guard;
    rdrdy = 1'b0; wrvld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wrdata = W'(i + 1);
      tick();
    end
    wrvld = 1'b0;
    tick();
    flush = 1'b1; wrvld = 1'b1; rdrdy = 1'b1; wrdata = 8'h55;
    #1;
    checks++; if (wrrdy !== 1'b0) begin errors++; $display("FAIL flush_wrrdy got %b exp 0", wrrdy); end
    tick();
    flush = 1'b0; wrvld = 1'b0; rdrdy = 1'b0;
    checks++; if (count !== '0 || rdvld !== 1'b0) begin errors++; $display("FAIL flush_state got cnt=%0d vld=%b exp 0/0", count, rdvld); end
    wrvld = 1'b1; wrdata = 8'hAA;
    tick();
    wrvld = 1'b0; guard = 0;
    while (rdvld !== 1'b1 && guard < 4) begin
      tick();
      guard++;
    end
    checks++; if (rdvld !== 1'b1 || rddata !== 8'hAA) begin errors++; $display("FAIL flush_next got vld=%b data=%h exp 1/aa", rdvld, rddata); end
    rdrdy = 1'b1;
    tick();
    rdrdy = 1'b0;
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_final got %0d exp 0", count); end
  endtask

  task automatic test_random();
    int wr_pct;
    int rd_pct;
    for (int i = 0; i < 400; i++) begin
      wr_pct = ((i / 50) % 2 == 0) ? 75 : 30;
      rd_pct = 100 - wr_pct;
      wrvld  = ($urandom_range(0, 99) < wr_pct);
      rdrdy  = ($urandom_range(0, 99) < rd_pct);
      flush  = ($urandom_range(0, 99) < 2);
      rst    = (i != 217);
      wrdata = W'($urandom);
      #1;
      checks++; if (wrrdy !== m_wrrdy()) begin errors++; $display("FAIL rnd_wrrdy i=%0d got %b exp %b", i, wrrdy, m_wrrdy()); end
      checks++; if (rdvld !== m_rdvld()) begin errors++; $display("FAIL rnd_rdvld i=%0d got %b exp %b", i, rdvld, m_rdvld()); end
      checks++; if (count !== WCNT'(mq.size())) begin errors++; $display("FAIL rnd_count i=%0d got %0d exp %0d", i, count, mq.size()); end
      checks++; if (afull !== (mq.size() >= AFULL) || aempty !== (mq.size() <= AEMPTY)) begin
        errors++; $display("FAIL rnd_flags i=%0d got af=%b ae=%b size=%0d", i, afull, aempty, mq.size());
      end
      if (m_rdvld()) begin
        checks++; if (rddata !== mq[0]) begin errors++; $display("FAIL rnd_data i=%0d got %h exp %h", i, rddata, mq[0]); end
      end
      tick();
    end
    wrvld = 1'b0; rdrdy = 1'b0; flush = 1'b0; rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_rw();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
